// File: rtl/tip_train_pkg.sv
// Shared constants for read-data tap training: FSM state encodings and strobe timing.
package tip_train_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_DWELL  = 3'd3;
  localparam logic [2:0] ST_EVAL   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int unsigned CLEAR_CYCLES = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pass_window_tracker.sv
// Tracks the current run of passing taps and the longest run seen so far in a sweep.
module pass_window_tracker #(
  parameter int unsigned TAP_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 eval,
  input  logic                 pass,
  input  logic [TAP_WIDTH-1:0] tap,
  output logic [TAP_WIDTH-1:0] best_start,
  output logic [TAP_WIDTH:0]   best_len
);

  logic [TAP_WIDTH-1:0] run_start, run_start_nxt;
  logic [TAP_WIDTH:0]   run_len, run_len_nxt;

  always_comb begin
    run_len_nxt   = '0;
    run_start_nxt = run_start;
    if (pass) begin
      run_len_nxt = run_len + 1'b1;
      if (run_len == '0) run_start_nxt = tap;
    end
  end

  // Strict compare on the post-update run keeps the earliest of equal-length windows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clr) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (eval) begin
      run_start <= run_start_nxt;
      run_len   <= run_len_nxt;
      if (run_len_nxt > best_len) begin
        best_start <= run_start_nxt;
        best_len   <= run_len_nxt;
      end
    end
  end

endmodule

// File: rtl/tap_sweep_controller.sv
// Steps the input-delay tap across its range, strobes flag clears, samples the flag per tap
// and reports the longest contiguous passing window with its centre tap.
module tap_sweep_controller
  import tip_train_pkg::*;
#(
  parameter int unsigned TAP_WIDTH     = 5,
  parameter int unsigned NUM_TAPS      = 32,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned DWELL_CYCLES  = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 flag,
  output logic [TAP_WIDTH-1:0] tap,
  output logic                 clear_flags,
  output logic                 busy,
  output logic                 done,
  output logic [TAP_WIDTH-1:0] window_start,
  output logic [TAP_WIDTH:0]   window_len,
  output logic [TAP_WIDTH-1:0] center_tap,
  output logic                 no_window
);

  localparam int unsigned CNT_MAX = max_u(max_u(SETTLE_CYCLES, DWELL_CYCLES), CLEAR_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0]     DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(NUM_TAPS - 1);

  logic [2:0]           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 last_tap;
  logic                 accept;
  logic [TAP_WIDTH-1:0] best_start;
  logic [TAP_WIDTH:0]   best_len;
  logic [TAP_WIDTH-1:0] live_start, live_center, res_start, res_center;
  logic [TAP_WIDTH:0]   res_len;
  logic                 live_none, res_none;

  assign last_tap = (tap == TAP_LAST);
  assign accept   = (state == ST_IDLE) && start;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_CLEAR;
      ST_CLEAR:  if (cnt == CLEAR_LAST) state_nxt = ST_DWELL;
      ST_DWELL:  if (cnt == DWELL_LAST) state_nxt = ST_EVAL;
      ST_EVAL:   state_nxt = last_tap ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // One counter serves every timed state; it restarts on each state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      tap         <= '0;
      clear_flags <= 1'b0;
    end else begin
      state       <= state_nxt;
      clear_flags <= (state_nxt == ST_CLEAR);
      if (state == ST_IDLE || state_nxt != state) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (accept) tap <= '0;
      else if (state == ST_EVAL && !last_tap) tap <= tap + 1'b1;
    end
  end

  pass_window_tracker #(
    .TAP_WIDTH(TAP_WIDTH)
  ) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .clr       (accept),
    .eval      (state == ST_EVAL),
    .pass      (~flag),
    .tap       (tap),
    .best_start(best_start),
    .best_len  (best_len)
  );

  always_comb begin
    live_none   = (best_len == '0);
    live_start  = live_none ? '0 : best_start;
    live_center = live_none ? '0 : best_start + TAP_WIDTH'(best_len >> 1);
  end

  // Results show live during the DONE cycle and are captured so they hold afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_start  <= '0;
      res_len    <= '0;
      res_center <= '0;
      res_none   <= 1'b0;
    end else if (state == ST_DONE) begin
      res_start  <= live_start;
      res_len    <= best_len;
      res_center <= live_center;
      res_none   <= live_none;
    end
  end

  assign done         = (state == ST_DONE);
  assign busy         = (state == ST_SETTLE) || (state == ST_CLEAR) ||
                        (state == ST_DWELL)  || (state == ST_EVAL);
  assign window_start = done ? live_start  : res_start;
  assign window_len   = done ? best_len    : res_len;
  assign center_tap   = done ? live_center : res_center;
  assign no_window    = done ? live_none   : res_none;

endmodule

// File: tb/tb_tap_sweep_controller.sv
// Scoreboarded directed bench: sweeps push expected results, monitors check them on done.
module tb_tap_sweep_controller;

  localparam int NT  = 8;
  localparam int SC  = 2;
  localparam int DC  = 4;
  localparam int LAT = NT * (SC + 2 + DC + 1) + 1;

  typedef struct {
    int ws;
    int wl;
    int ct;
    int nw;
    int cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       start_a = 1'b0, flag_a, clear_a, busy_a, done_a, nw_a;
  logic [4:0] tap_a, ws_a, ct_a;
  logic [5:0] wl_a;
  logic [31:0] fail_a = '0;
  logic       pulse_a = 1'b0;

  logic       start_b = 1'b0, flag_b, clear_b, busy_b, done_b, nw_b;
  logic [2:0] tap_b, ws_b, ct_b;
  logic [3:0] wl_b;
  logic [7:0] fail_b = '0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t last_a;
  int applied = 0, miscompares = 0, cyc = 0, clr_cnt_a = 0, clr_run_a = 0;

  tap_sweep_controller #(.TAP_WIDTH(5), .NUM_TAPS(NT), .SETTLE_CYCLES(SC), .DWELL_CYCLES(DC)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .flag(flag_a), .tap(tap_a),
    .clear_flags(clear_a), .busy(busy_a), .done(done_a), .window_start(ws_a),
    .window_len(wl_a), .center_tap(ct_a), .no_window(nw_a)
  );

  tap_sweep_controller #(.TAP_WIDTH(3), .NUM_TAPS(NT), .SETTLE_CYCLES(SC), .DWELL_CYCLES(DC)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .flag(flag_b), .tap(tap_b),
    .clear_flags(clear_b), .busy(busy_b), .done(done_b), .window_start(ws_b),
    .window_len(wl_b), .center_tap(ct_b), .no_window(nw_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Sticky flag generator: set by noise on a failing tap, cleared by the strobe.
  always @(posedge clock or posedge reset) begin
    if (reset) flag_a <= 1'b0;
    else if (clear_a) flag_a <= 1'b0;
    else if (fail_a[tap_a] || pulse_a) flag_a <= 1'b1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) flag_b <= 1'b0;
    else if (clear_b) flag_b <= 1'b0;
    else if (fail_b[tap_b]) flag_b <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    applied++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (clear_a) begin
        clr_cnt_a++;
        clr_run_a++;
      end else if (clr_run_a != 0) begin
        chk("clear_width", clr_run_a, 2);
        clr_run_a = 0;
      end
      if (done_a) begin
        if (q_a.size() == 0) chk("unexpected_done_a", 1, 0);
        else begin
          exp_t e;
          e = q_a.pop_front();
          chk("window_start_a", ws_a, e.ws);
          chk("window_len_a", wl_a, e.wl);
          chk("center_tap_a", ct_a, e.ct);
          chk("no_window_a", nw_a, e.nw);
          chk("done_cycle_a", cyc, e.cyc);
          last_a = e;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && done_b) begin
      if (q_b.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("window_start_b", ws_b, e.ws);
        chk("window_len_b", wl_b, e.wl);
        chk("center_tap_b", ct_b, e.ct);
        chk("no_window_b", nw_b, e.nw);
        chk("done_cycle_b", cyc, e.cyc);
      end
    end
  end

  task automatic sweep_a(input logic [31:0] fail, input int ws, input int wl, input int ct,
                         input int nw);
    exp_t e;
    int n;
    @(negedge clock);
    fail_a    = fail;
    start_a   = 1'b1;
    clr_cnt_a = 0;
    e.ws = ws; e.wl = wl; e.ct = ct; e.nw = nw; e.cyc = cyc + LAT;
    q_a.push_back(e);
    @(negedge clock);
    start_a = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("tap_first", tap_a, 0);
    n = 0;
    while (q_a.size() != 0 && n < LAT + 20) begin
      @(negedge clock);
      n++;
    end
    if (q_a.size() != 0) begin
      chk("done_timeout_a", 0, 1);
      q_a.delete();
    end
    @(negedge clock);
    chk("busy_after_done", busy_a, 0);
    chk("clear_count", clr_cnt_a, 2 * NT);
  endtask

  task automatic check_hold_a();
    repeat (3) @(negedge clock);
    chk("hold_start", ws_a, last_a.ws);
    chk("hold_len", wl_a, last_a.wl);
    chk("hold_center", ct_a, last_a.ct);
    chk("hold_no_window", nw_a, last_a.nw);
    chk("hold_done_low", done_a, 0);
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_tap"}, tap_a, 0);
    chk({tag, "_clear"}, clear_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_ws"}, ws_a, 0);
    chk({tag, "_wl"}, wl_a, 0);
    chk({tag, "_ct"}, ct_a, 0);
    chk({tag, "_nw"}, nw_a, 0);
  endtask

  initial begin
    int n;
    exp_t eb;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_zero_a("reset");
    reset = 1'b0;

    sweep_a(32'h0000_00C3, 2, 4, 4, 0);
    check_hold_a();
    sweep_a(32'h0000_00FF, 0, 0, 0, 1);
    check_hold_a();
    sweep_a(32'h0000_0099, 1, 2, 2, 0);
    sweep_a(32'h0000_001F, 5, 3, 6, 0);

    fork
      sweep_a(32'h0000_0000, 4, 4, 6, 0);
      begin
        n = 0;
        while (!(tap_a == 5'd3 && clear_a) && n < LAT) begin @(negedge clock); n++; end
        while (clear_a && n < LAT) begin @(negedge clock); n++; end
        @(negedge clock);
        pulse_a = 1'b1;
        @(negedge clock);
        pulse_a = 1'b0;
      end
    join

    fork
      sweep_a(32'h0000_00C3, 2, 4, 4, 0);
      begin
        n = 0;
        while (tap_a != 5'd2 && n < LAT) begin @(negedge clock); n++; end
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        while (!done_a && n < 2 * LAT) begin @(negedge clock); n++; end
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        chk("start_at_done_ignored", busy_a, 0);
      end
    join

    @(negedge clock);
    fail_a  = '0;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    n = 0;
    while (!(tap_a == 5'd4 && clear_a) && n < LAT) begin @(negedge clock); n++; end
    while (clear_a && n < LAT) begin @(negedge clock); n++; end
    chk("reached_dwell_tap4", tap_a, 4);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_zero_a("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (LAT) @(negedge clock);
    chk("no_done_after_abort", done_a, 0);
    sweep_a(32'h0000_00C3, 2, 4, 4, 0);

    @(negedge clock);
    fail_b  = '0;
    start_b = 1'b1;
    eb.ws = 0; eb.wl = 8; eb.ct = 4; eb.nw = 0; eb.cyc = cyc + LAT;
    q_b.push_back(eb);
    @(negedge clock);
    start_b = 1'b0;
    n = 0;
    while (q_b.size() != 0 && n < LAT + 20) begin @(negedge clock); n++; end
    if (q_b.size() != 0) begin
      chk("done_timeout_b", 0, 1);
      q_b.delete();
    end

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
